// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// opcode/funct values, ALU operation classes and ALU control codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation classes selected by the FSM
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU control codes seen by the datapath ALU
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Per-state datapath controls (everything except alu_control/state)
    typedef struct packed {
        logic       mem_to_reg;
        logic       reg_dest;
        logic       i_or_d;
        logic       alu_src_a;
        logic       ir_write;
        logic       mem_write;
        logic       pc_write;
        logic       branch;
        logic       reg_write;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle. The controller side (master) drives all
// selects and enables; the datapath side (slave) supplies opcode/funct.
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_to_reg;
    logic       reg_dest;
    logic       i_or_d;
    logic       alu_src_a;
    logic       ir_write;
    logic       mem_write;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  opcode, funct,
        output mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write, mem_write,
               pc_write, branch, reg_write, alu_src_b, pc_src, alu_control,
               state, instr_done, illegal_op
    );

    modport slave (
        output opcode, funct,
        input  mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write, mem_write,
               pc_write, branch, reg_write, alu_src_b, pc_src, alu_control,
               state, instr_done, illegal_op
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU operation class and the
// R-type funct field onto an ALU control code. Reused by pipelined cores.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    // Decode operation class, falling back to funct for R-type execution
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS main control unit: Moore FSM stepping one instruction
// phase per cycle, plus the ALU decoder. All outputs are held at zero
// while reset is high so no write can fire in a reset cycle.
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master bus
);

    state_t     state_q;
    state_t     state_d;
    ctrl_t      ctrl_c;
    logic [1:0] alu_op_c;
    logic       valid_c;
    logic [2:0] alu_control_c;

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state output decode
    always_comb begin
        state_d  = FETCH;
        ctrl_c   = '0;
        alu_op_c = ALUOP_ADD;
        valid_c  = 1'b1;
        case (state_q)
            FETCH: begin
                ctrl_c.ir_write  = 1'b1;
                ctrl_c.pc_write  = 1'b1;
                ctrl_c.alu_src_b = 2'b01;
                state_d          = DECODE;
            end
            DECODE: begin
                ctrl_c.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d           = FETCH;
                        ctrl_c.illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = 2'b10;
                state_d          = (bus.opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                ctrl_c.i_or_d = 1'b1;
                state_d       = MEMWB;
            end
            MEMWB: begin
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            MEMWRITE: begin
                ctrl_c.i_or_d     = 1'b1;
                ctrl_c.mem_write  = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            EXECUTE: begin
                ctrl_c.alu_src_a = 1'b1;
                alu_op_c         = ALUOP_FUNCT;
                state_d          = ALUWB;
            end
            ALUWB: begin
                ctrl_c.reg_dest   = 1'b1;
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl_c.alu_src_a  = 1'b1;
                ctrl_c.pc_src     = 2'b01;
                ctrl_c.branch     = 1'b1;
                ctrl_c.instr_done = 1'b1;
                alu_op_c          = ALUOP_SUB;
            end
            ADDIEXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = 2'b10;
                state_d          = ADDIWB;
            end
            ADDIWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            JUMP: begin
                ctrl_c.pc_src     = 2'b10;
                ctrl_c.pc_write   = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            default: begin
                valid_c = 1'b0;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op_c),
        .funct       (bus.funct),
        .alu_control (alu_control_c)
    );

    // Reset and unreachable encodings blank every output, including alu_control
    ctrl_t ctrl_o;
    assign ctrl_o = (reset || !valid_c) ? '0 : ctrl_c;

    assign bus.mem_to_reg  = ctrl_o.mem_to_reg;
    assign bus.reg_dest    = ctrl_o.reg_dest;
    assign bus.i_or_d      = ctrl_o.i_or_d;
    assign bus.alu_src_a   = ctrl_o.alu_src_a;
    assign bus.ir_write    = ctrl_o.ir_write;
    assign bus.mem_write   = ctrl_o.mem_write;
    assign bus.pc_write    = ctrl_o.pc_write;
    assign bus.branch      = ctrl_o.branch;
    assign bus.reg_write   = ctrl_o.reg_write;
    assign bus.alu_src_b   = ctrl_o.alu_src_b;
    assign bus.pc_src      = ctrl_o.pc_src;
    assign bus.instr_done  = ctrl_o.instr_done;
    assign bus.illegal_op  = ctrl_o.illegal_op;
    assign bus.alu_control = (reset || !valid_c) ? '0 : alu_control_c;
    assign bus.state       = (reset || !valid_c) ? '0 : state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller: walks each instruction class
// cycle by cycle and compares the full output vector against hand-built
// per-state expectations.
module tb_multicycle_controller;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected-vector builder; field order matches outs()
    function automatic logic [21:0] vec(
        input logic m2r, input logic rd, input logic iod, input logic asa,
        input logic irw, input logic mw, input logic pcw, input logic br,
        input logic rw, input logic [1:0] asb, input logic [1:0] pcs,
        input logic [2:0] ac, input logic [3:0] st, input logic done,
        input logic ill);
        return {m2r, rd, iod, asa, irw, mw, pcw, br, rw, asb, pcs, ac, st, done, ill};
    endfunction

    function automatic logic [21:0] outs();
        return {bus.mem_to_reg, bus.reg_dest, bus.i_or_d, bus.alu_src_a,
                bus.ir_write, bus.mem_write, bus.pc_write, bus.branch,
                bus.reg_write, bus.alu_src_b, bus.pc_src, bus.alu_control,
                bus.state, bus.instr_done, bus.illegal_op};
    endfunction

    //                                 m2r  rd  iod asa irw mw pcw br  rw  asb    pcs    ac      st  done ill
    localparam logic [21:0] V_ZERO = 22'd0;
    localparam logic [21:0] V_FET  = vec(0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b01, 2'b00, 3'b010, 4'd0,  0, 0);
    localparam logic [21:0] V_DEC  = vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 4'd1,  0, 0);
    localparam logic [21:0] V_DECI = vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 4'd1,  0, 1);
    localparam logic [21:0] V_MADR = vec(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 3'b010, 4'd2,  0, 0);
    localparam logic [21:0] V_MRD  = vec(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 4'd3,  0, 0);
    localparam logic [21:0] V_MWB  = vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 4'd4,  1, 0);
    localparam logic [21:0] V_MWR  = vec(0, 0, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 4'd5,  1, 0);
    localparam logic [21:0] V_AWB  = vec(0, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 4'd7,  1, 0);
    localparam logic [21:0] V_BR   = vec(0, 0, 0, 1, 0, 0, 0, 1, 0, 2'b00, 2'b01, 3'b110, 4'd8,  1, 0);
    localparam logic [21:0] V_AIEX = vec(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 3'b010, 4'd9,  0, 0);
    localparam logic [21:0] V_AIWB = vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 4'd10, 1, 0);
    localparam logic [21:0] V_JMP  = vec(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 3'b010, 4'd11, 1, 0);

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [21:0] got;
        reset = 1'b1;
        bus.opcode = 6'b000000;
        bus.funct  = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            got = outs();
            checks++;
            if (got !== V_ZERO) begin
                failures++;
                $display("FAIL reset_hold[%0d] got=%h exp=%h", i, got, V_ZERO);
            end
        end
        reset = 1'b0;
        #1;
        got = outs();
        checks++;
        if (got !== V_FET) begin
            failures++;
            $display("FAIL reset_release_fetch got=%h exp=%h", got, V_FET);
        end
    endtask

    // Caller leaves the DUT in a FETCH cycle; every task returns in FETCH too
    task automatic test_lw();
        logic [21:0] exp [6];
        logic [21:0] got;
        exp = '{V_FET, V_DEC, V_MADR, V_MRD, V_MWB, V_FET};
        bus.opcode = 6'b100011;
        bus.funct  = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) next_cycle();
            got = outs();
            checks++;
            if (got !== exp[i]) begin
                failures++;
                $display("FAIL lw_cycle%0d got=%h exp=%h", i + 1, got, exp[i]);
            end
        end
    endtask

    task automatic test_rtype(input logic [5:0] fn, input logic [2:0] ac);
        logic [21:0] exp [5];
        logic [21:0] got;
        exp = '{V_FET, V_DEC,
                vec(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, ac, 4'd6, 0, 0),
                V_AWB, V_FET};
        bus.opcode = 6'b000000;
        bus.funct  = fn;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) next_cycle();
            got = outs();
            checks++;
            if (got !== exp[i]) begin
                failures++;
                $display("FAIL rtype_fn%b_cycle%0d got=%h exp=%h", fn, i + 1, got, exp[i]);
            end
        end
    endtask

    task automatic test_addi();
        logic [21:0] exp [5];
        logic [21:0] got;
        exp = '{V_FET, V_DEC, V_AIEX, V_AIWB, V_FET};
        bus.opcode = 6'b001000;
        bus.funct  = 6'b101010;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) next_cycle();
            got = outs();
            checks++;
            if (got !== exp[i]) begin
                failures++;
                $display("FAIL addi_cycle%0d got=%h exp=%h", i + 1, got, exp[i]);
            end
        end
    endtask

    task automatic test_branch_jump();
        logic [21:0] exp_b [4];
        logic [21:0] exp_j [4];
        logic [21:0] got;
        exp_b = '{V_FET, V_DEC, V_BR, V_FET};
        exp_j = '{V_FET, V_DEC, V_JMP, V_FET};
        bus.opcode = 6'b000100;
        bus.funct  = 6'b100101;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) next_cycle();
            got = outs();
            checks++;
            if (got !== exp_b[i]) begin
                failures++;
                $display("FAIL beq_cycle%0d got=%h exp=%h", i + 1, got, exp_b[i]);
            end
        end
        bus.opcode = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) next_cycle();
            got = outs();
            checks++;
            if (got !== exp_j[i]) begin
                failures++;
                $display("FAIL j_cycle%0d got=%h exp=%h", i + 1, got, exp_j[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [21:0] exp [3];
        logic [21:0] got;
        exp = '{V_FET, V_DECI, V_FET};
        bus.opcode = 6'b111111;
        bus.funct  = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) next_cycle();
            got = outs();
            checks++;
            if (got !== exp[i]) begin
                failures++;
                $display("FAIL illegal_cycle%0d got=%h exp=%h", i + 1, got, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [21:0] exp [4];
        logic [21:0] got;
        exp = '{V_FET, V_DEC, V_MADR, V_MWR};
        bus.opcode = 6'b101011;
        bus.funct  = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) next_cycle();
            got = outs();
            checks++;
            if (got !== exp[i]) begin
                failures++;
                $display("FAIL sw_cycle%0d got=%h exp=%h", i + 1, got, exp[i]);
            end
        end
        // Assert reset inside MEMWRITE: mem_write must drop in that cycle
        reset = 1'b1;
        #1;
        got = outs();
        checks++;
        if (got !== V_ZERO) begin
            failures++;
            $display("FAIL reset_in_memwrite got=%h exp=%h", got, V_ZERO);
        end
        next_cycle();
        got = outs();
        checks++;
        if (got !== V_ZERO) begin
            failures++;
            $display("FAIL reset_cycle_after got=%h exp=%h", got, V_ZERO);
        end
        reset = 1'b0;
        #1;
        got = outs();
        checks++;
        if (got !== V_FET) begin
            failures++;
            $display("FAIL reset_mid_release got=%h exp=%h", got, V_FET);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.opcode = 6'b000000;
        bus.funct  = 6'b000000;
        test_reset();
        test_lw();
        test_rtype(6'b100010, 3'b110);
        test_rtype(6'b101010, 3'b111);
        test_rtype(6'b100100, 3'b000);
        test_rtype(6'b100101, 3'b001);
        test_rtype(6'b100000, 3'b010);
        test_rtype(6'b111111, 3'b010);
        test_addi();
        test_branch_jump();
        test_illegal();
        test_reset_mid();
        test_lw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control unit for the multicycle MIPS core. It sits directly upstream of the datapath: it consumes `opcode`/`funct` from the datapath's instruction register and drives every datapath select and write-enable. It is a Moore FSM, one instruction step per cycle, plus a combinational ALU decoder. It also provides an instruction-retired pulse and an illegal-opcode pulse for the core and for debug.

Parameters:
- none. All encodings are fixed in the shared package.

Ports:
- clk  input  1  core clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- opcode  input  6  instr[31:26] from the datapath.
- funct  input  6  instr[5:0] from the datapath.
- mem_to_reg  output  1  1 = register write data from the memory-data register; 0 = alu_out.
- reg_dest  output  1  1 = write register rd; 0 = rt.
- i_or_d  output  1  1 = memory address is alu_out; 0 = pc.
- alu_src_a  output  1  1 = register A; 0 = pc.
- ir_write  output  1  load the instruction register.
- mem_write  output  1  memory write enable.
- pc_write  output  1  unconditional PC load.
- branch  output  1  PC load qualified by ALU zero.
- reg_write  output  1  register file write enable.
- alu_src_b  output  2  00 = B; 01 = constant 4; 10 = sign-extended immediate; 11 = sign-extended immediate << 2.
- pc_src  output  2  00 = alu_result; 01 = alu_out; 10 = jump target.
- alu_control  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- state  output  4  current FSM state encoding, for debug.
- instr_done  output  1  one-cycle pulse in the last state of each instruction.
- illegal_op  output  1  one-cycle pulse in DECODE when the opcode is unsupported.

Behaviour:
- The state register updates on the rising edge of clk.
- While reset is sampled high, the next state is FETCH.
- While reset is high, every output is forced to 0. This includes all write enables and `state`. Outputs decode normally from the first cycle after reset deasserts, and that cycle is FETCH.
- Outputs decode from the current state only. Exception: alu_control also depends on funct whenever alu_op = 10.
- Any output not listed for a state is 0. alu_op is internal to the block.

States, their asserted outputs, and next state:
- FETCH: ir_write=1, pc_write=1, alu_src_b=01, alu_op=00. Next: DECODE.
- DECODE: alu_src_b=11, alu_op=00 (precomputes the branch target). Next, by opcode:
  - lw (100011) or sw (101011) -> MEMADR
  - R-type (000000) -> EXECUTE
  - beq (000100) -> BRANCH
  - addi (001000) -> ADDIEXEC
  - j (000010) -> JUMP
  - anything else -> FETCH, with illegal_op=1.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: i_or_d=1. Next: MEMWB.
- MEMWB: mem_to_reg=1, reg_write=1, instr_done=1. Next: FETCH.
- MEMWRITE: i_or_d=1, mem_write=1, instr_done=1. Next: FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
- ALUWB: reg_dest=1, reg_write=1, instr_done=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1, instr_done=1. Next: FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
- ADDIWB: reg_write=1, instr_done=1. Next: FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1. Next: FETCH.

Latency in cycles, counted from FETCH and including it:
- lw 5
- sw, R-type, addi 4
- beq, j 3
- illegal opcode 2

ALU decoder:
- alu_op 00 -> 010 (ADD).
- alu_op 01 -> 110 (SUB).
- alu_op 10, by funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - any other funct -> 010.
- An unsupported funct does not raise illegal_op.

Boundary conditions:
- opcode and funct are only interpreted in DECODE, EXECUTE and MEMADR. The instruction register holds them stable after FETCH.
- An unreachable state encoding -> next state FETCH, all outputs 0.
- Reset mid-instruction: the next cycle has all outputs 0, and the cycle after reset deasserts is FETCH. No partial write may occur in the reset cycle.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state_t enum (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
  - Opcode and funct constants.
  - alu_op and alu_control code constants.
- One combinational sub-module, alu_decoder (alu_op, funct -> alu_control). It is reused by later pipelined cores.

Test Plan:
- Reset: hold reset high for 3 cycles -> all outputs 0, state=0. Release -> FETCH with ir_write=1, pc_write=1, alu_src_b=01, alu_control=010.
- lw, opcode 100011 -> state sequence 0,1,2,3,4. MEMREAD has i_or_d=1. MEMWB has reg_write=1, mem_to_reg=1, instr_done=1. Back to 0 on cycle 6.
- R-type: opcode 0 with funct 100010 -> EXECUTE has alu_control=110, alu_src_a=1, alu_src_b=00. ALUWB has reg_dest=1, reg_write=1. Repeat with funct 101010 -> 111; funct 100100 -> 000; funct 111111 -> 010.
- beq (000100) and j (000010):
  - beq -> BRANCH has branch=1, pc_src=01, alu_control=110, pc_write=0.
  - j -> JUMP has pc_src=10, pc_write=1. Each takes 3 cycles.
- Illegal opcode 111111 -> DECODE shows illegal_op=1 for exactly one cycle, next state FETCH, no write enable asserted.
- Reset asserted in MEMWRITE of sw (101011) -> mem_write=0 in the reset cycle, and FETCH on the first cycle after release.
